// File: rtl/prog_load_run_ctrl_pkg.sv
// Shared types and constants for the program load / run sequencer.
// State encoding, default halt word and a width helper.
package prog_load_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  // MIPS syscall encoding ends a run
  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_000C;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prog_load_run_ctrl_load_addr_gen.sv
// Load index counter and instruction-memory address generator.
// Tracks words written, the next write address and load overflow.
module prog_load_run_ctrl_load_addr_gen
  import prog_load_run_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ADDR_STEP = 4,
  parameter int unsigned       CNT_W     = clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              accept_i,
  input  logic              last_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_slot_o,
  output logic              full_o,
  output logic              ovf_o
);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(ADDR_STEP);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;

  assign full_o      = (cnt_q >= DEPTH_C);
  assign last_slot_o = (cnt_q == DEPTH_C - ONE_C);
  assign count_o     = cnt_q;
  assign addr_o      = addr_q;
  assign ovf_o       = ovf_q;

  // Advance index and running address on each accepted beat
  always_comb begin
    cnt_d  = cnt_q;
    nxt_d  = nxt_q;
    addr_d = addr_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      nxt_d = BASE_ADDR;
      ovf_d = 1'b0;
    end else if (accept_i && !full_o) begin
      cnt_d  = cnt_q + ONE_C;
      addr_d = nxt_q;
      nxt_d  = nxt_q + STEP_C;
      if (last_slot_o && !last_i) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Index, address and overflow registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      nxt_q  <= BASE_ADDR;
      addr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      nxt_q  <= nxt_d;
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/prog_load_run_ctrl.sv
// Program load and run-control sequencer for the single-cycle core.
// Streams words into IF memory under reset, then runs to halt/budget.
module prog_load_run_ctrl
  import prog_load_run_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH      = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       ADDR_STEP  = 4,
  parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(HALT_WORD_DEF),
  parameter int unsigned       MAX_CYCLES = 1024,
  localparam int unsigned      LC_W = clog2(DEPTH + 1),
  localparam int unsigned      CC_W = clog2(MAX_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] ins,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [LC_W-1:0]   load_count,
  output logic [CC_W-1:0]   cycle_count,
  output logic [ADDR_W-1:0] halt_pc
);

  localparam logic [CC_W-1:0] MAX_C = CC_W'(MAX_CYCLES);
  localparam logic [CC_W-1:0] ONE_C = CC_W'(1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic [CC_W-1:0]   cyc_q, cyc_d;
  logic [CC_W-1:0]   run_k;
  logic [ADDR_W-1:0] hpc_q, hpc_d;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              accept;
  logic              clr;
  logic              full;
  logic              last_slot;

  // A load ends after the beat that carries last or fills DEPTH
  assign in_ready = (state_q == S_LOAD) && !full && !last_q;
  assign accept   = in_valid && in_ready;

  prog_load_run_ctrl_load_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_STEP (ADDR_STEP),
    .CNT_W     (LC_W)
  ) u_addr_gen (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       (clr),
    .accept_i    (accept),
    .last_i      (in_last),
    .count_o     (load_count),
    .addr_o      (wr_addr),
    .last_slot_o (last_slot),
    .full_o      (full),
    .ovf_o       (overflow)
  );

  // Next-state, run counter and completion flags
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    done_d  = done_q;
    to_d    = to_q;
    cyc_d   = cyc_q;
    hpc_d   = hpc_q;
    clr     = 1'b0;
    run_k   = (cyc_q == MAX_C) ? cyc_q : cyc_q + ONE_C;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_LOAD;
          clr     = 1'b1;
          last_d  = 1'b0;
          done_d  = 1'b0;
          to_d    = 1'b0;
          cyc_d   = '0;
        end
      end
      S_LOAD: begin
        if (last_q) begin
          state_d = S_RUN;
        end else if (accept && (in_last || last_slot)) begin
          last_d = 1'b1;
        end
      end
      S_RUN: begin
        cyc_d = run_k;
        if (ins == HALT_WORD) begin
          state_d = S_HALT;
          done_d  = 1'b1;
          hpc_d   = pc;
        end else if (run_k == MAX_C) begin
          state_d = S_HALT;
          to_d    = 1'b1;
          hpc_d   = pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and run status registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      done_q  <= done_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      hpc_q   <= hpc_d;
    end
  end

  // Accepted beat becomes a one-cycle IF memory write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_data_q <= in_data;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign core_rst    = !((state_q == S_RUN) || (state_q == S_HALT));
  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done        = done_q;
  assign timeout     = to_q;
  assign cycle_count = cyc_q;
  assign halt_pc     = hpc_q;

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Bench for prog_load_run_ctrl: two configurations, a simple core
// model fetching from a write-captured IF memory, and a run model.
module tb_prog_load_run_ctrl;
  import prog_load_run_ctrl_pkg::*;

  localparam int LCA = clog2(257);
  localparam int CCA = clog2(17);
  localparam int LCB = clog2(5);
  localparam int CCB = clog2(21);
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        start_s[2], in_valid_s[2], in_last_s[2];
  logic [31:0] in_data_s[2];
  logic        in_ready_s[2], wr_en_s[2], core_rst_s[2];
  logic        busy_s[2], done_s[2], to_s[2], ovf_s[2];
  logic [31:0] wr_addr_s[2], wr_data_s[2], halt_pc_s[2];
  logic [31:0] pc_s[2], ins_s[2];
  logic [LCA-1:0] lc_a;
  logic [LCB-1:0] lc_b;
  logic [CCA-1:0] cc_a;
  logic [CCB-1:0] cc_b;
  int lc_s[2], cc_s[2];
  logic [31:0] mem[2][256];
  logic mem_clr[2];
  logic [63:0] wq0[$], wq1[$];
  int n_vec, n_err;

  always_comb begin
    lc_s[0] = int'(lc_a);
    lc_s[1] = int'(lc_b);
    cc_s[0] = int'(cc_a);
    cc_s[1] = int'(cc_b);
  end

  prog_load_run_ctrl #(
    .DEPTH(256), .MAX_CYCLES(16)
  ) u_a (
    .CLK(CLK), .RST(RST), .start(start_s[0]),
    .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
    .in_last(in_last_s[0]), .in_ready(in_ready_s[0]),
    .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]),
    .wr_data(wr_data_s[0]), .core_rst(core_rst_s[0]),
    .pc(pc_s[0]), .ins(ins_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .timeout(to_s[0]),
    .overflow(ovf_s[0]), .load_count(lc_a),
    .cycle_count(cc_a), .halt_pc(halt_pc_s[0])
  );

  prog_load_run_ctrl #(
    .DEPTH(4), .MAX_CYCLES(20)
  ) u_b (
    .CLK(CLK), .RST(RST), .start(start_s[1]),
    .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
    .in_last(in_last_s[1]), .in_ready(in_ready_s[1]),
    .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]),
    .wr_data(wr_data_s[1]), .core_rst(core_rst_s[1]),
    .pc(pc_s[1]), .ins(ins_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .timeout(to_s[1]),
    .overflow(ovf_s[1]), .load_count(lc_b),
    .cycle_count(cc_b), .halt_pc(halt_pc_s[1])
  );

  // IF memory and a PC that advances one word per unreset cycle
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clr[d]) begin
        for (int k = 0; k < 256; k++) mem[d][k] <= 32'h0;
      end else if (wr_en_s[d]) begin
        mem[d][wr_addr_s[d][9:2]] <= wr_data_s[d];
      end
      if (core_rst_s[d]) pc_s[d] <= 32'h0;
      else pc_s[d] <= pc_s[d] + 32'd4;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) ins_s[d] = mem[d][pc_s[d][9:2]];
  end

  always @(negedge CLK) begin
    if (wr_en_s[0]) wq0.push_back({wr_addr_s[0], wr_data_s[0]});
    if (wr_en_s[1]) wq1.push_back({wr_addr_s[1], wr_data_s[1]});
  end

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) #8;
      else begin
        #4 RST = 1'b0;
        @(negedge CLK);
      end
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (core_rst_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_ctrl[%0d.%0d]: core_rst=%b busy=%b want 1/0",
                   p, d, core_rst_s[d], busy_s[d]);
        end
        n_vec++;
        if (wr_en_s[d] !== 1'b0 || in_ready_s[d] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_hs[%0d.%0d]: wr_en=%b in_ready=%b want 0/0",
                   p, d, wr_en_s[d], in_ready_s[d]);
        end
        n_vec++;
        if ({done_s[d], to_s[d], ovf_s[d]} !== 3'b000) begin
          n_err++;
          $display("FAIL reset_flags[%0d.%0d]: got %b%b%b want 000",
                   p, d, done_s[d], to_s[d], ovf_s[d]);
        end
        n_vec++;
        if (lc_s[d] != 0 || cc_s[d] != 0 || halt_pc_s[d] !== 32'h0
            || wr_addr_s[d] !== 32'h0 || wr_data_s[d] !== 32'h0) begin
          n_err++;
          $display("FAIL reset_cnt[%0d.%0d]: lc=%0d cc=%0d hpc=%h want 0",
                   p, d, lc_s[d], cc_s[d], halt_pc_s[d]);
        end
      end
    end
  endtask

  task automatic load_and_run(input int d, input logic [31:0] w[$],
                              input bit mark_last, input int max_gap,
                              input string nm);
    int depth, maxc, len, acc, tries, n_exp, k_halt, to, cyc_exp;
    bit ovf_exp, term, done_exp;
    logic [31:0] hpc_exp, wd;
    logic [63:0] obs[$];
    depth = (d == 0) ? 256 : 4;
    maxc  = (d == 0) ? 16 : 20;
    len   = w.size();
    mem_clr[d] = 1'b1;
    @(posedge CLK);
    #1 mem_clr[d] = 1'b0;
    if (d == 0) wq0.delete();
    else wq1.delete();
    @(negedge CLK);
    start_s[d] = 1'b1;
    @(negedge CLK);
    start_s[d] = 1'b0;
    n_vec++;
    if (busy_s[d] !== 1'b1 || core_rst_s[d] !== 1'b1 || in_ready_s[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_state: busy=%b core_rst=%b in_ready=%b want 1/1/1",
               nm, busy_s[d], core_rst_s[d], in_ready_s[d]);
    end
    n_vec++;
    if (lc_s[d] != 0 || cc_s[d] != 0 || {done_s[d], to_s[d], ovf_s[d]} !== 3'b000) begin
      n_err++;
      $display("FAIL %s start_clear: lc=%0d cc=%0d flags=%b%b%b want 0",
               nm, lc_s[d], cc_s[d], done_s[d], to_s[d], ovf_s[d]);
    end
    acc = 0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = w[i];
      in_last_s[d]  = mark_last && (i == len - 1);
      tries = 0;
      while (!in_ready_s[d] && tries < 4) begin
        @(negedge CLK);
        tries++;
      end
      if (!in_ready_s[d]) begin
        in_valid_s[d] = 1'b0;
        in_last_s[d]  = 1'b0;
        break;
      end
      term = (acc + 1 == depth) || in_last_s[d];
      @(negedge CLK);
      acc++;
      in_valid_s[d] = 1'b0;
      in_last_s[d]  = 1'b0;
      if (term) begin
        n_vec++;
        if (wr_en_s[d] !== 1'b1 || in_ready_s[d] !== 1'b0
            || core_rst_s[d] !== 1'b1 || lc_s[d] != acc) begin
          n_err++;
          $display("FAIL %s last_write: wr_en=%b rdy=%b crst=%b lc=%0d want 1/0/1/%0d",
                   nm, wr_en_s[d], in_ready_s[d], core_rst_s[d], lc_s[d], acc);
        end
        @(negedge CLK);
        n_vec++;
        if (core_rst_s[d] !== 1'b0 || busy_s[d] !== 1'b1) begin
          n_err++;
          $display("FAIL %s release: core_rst=%b busy=%b want 0/1",
                   nm, core_rst_s[d], busy_s[d]);
        end
        if (i < len - 1) begin
          in_valid_s[d] = 1'b1;
          in_data_s[d]  = w[i+1];
          repeat (3) @(negedge CLK);
          n_vec++;
          if (in_ready_s[d] !== 1'b0) begin
            n_err++;
            $display("FAIL %s extra_beat: in_ready=%b want 0", nm, in_ready_s[d]);
          end
          in_valid_s[d] = 1'b0;
        end
        break;
      end
    end
    to = 0;
    while (!(done_s[d] || to_s[d]) && to < 200) begin
      @(negedge CLK);
      to++;
    end
    n_vec++;
    if (to >= 200) begin
      n_err++;
      $display("FAIL %s run_end: no done/timeout within %0d cycles", nm, to);
    end
    n_exp   = (len < depth) ? len : depth;
    ovf_exp = (len > depth) || (len == depth && !mark_last);
    k_halt  = -1;
    for (int k = 0; k < maxc; k++) begin
      wd = (k < n_exp) ? w[k] : 32'h0;
      if (wd == HALT && k_halt < 0) k_halt = k;
    end
    done_exp = (k_halt >= 0);
    cyc_exp  = done_exp ? k_halt + 1 : maxc;
    hpc_exp  = done_exp ? 32'(4 * k_halt) : 32'(4 * (maxc - 1));
    if (d == 0) obs = wq0;
    else obs = wq1;
    n_vec++;
    if (acc != n_exp || obs.size() != n_exp || lc_s[d] != n_exp) begin
      n_err++;
      $display("FAIL %s load_len: acc=%0d writes=%0d lc=%0d want %0d",
               nm, acc, obs.size(), lc_s[d], n_exp);
    end
    for (int j = 0; j < obs.size() && j < n_exp; j++) begin
      n_vec++;
      if (obs[j] !== {32'(4 * j), w[j]}) begin
        n_err++;
        $display("FAIL %s write[%0d]: got %h want %h",
                 nm, j, obs[j], {32'(4 * j), w[j]});
      end
    end
    n_vec++;
    if (ovf_s[d] !== ovf_exp) begin
      n_err++;
      $display("FAIL %s overflow: got %b want %b", nm, ovf_s[d], ovf_exp);
    end
    n_vec++;
    if (done_s[d] !== done_exp || to_s[d] !== !done_exp) begin
      n_err++;
      $display("FAIL %s outcome: done=%b timeout=%b want %b/%b",
               nm, done_s[d], to_s[d], done_exp, !done_exp);
    end
    n_vec++;
    if (cc_s[d] != cyc_exp || halt_pc_s[d] !== hpc_exp) begin
      n_err++;
      $display("FAIL %s run_stats: cc=%0d hpc=%h want %0d/%h",
               nm, cc_s[d], halt_pc_s[d], cyc_exp, hpc_exp);
    end
    repeat (3) @(negedge CLK);
    n_vec++;
    if (cc_s[d] != cyc_exp || done_s[d] !== done_exp || busy_s[d] !== 1'b0
        || core_rst_s[d] !== 1'b0 || wr_en_s[d] !== 1'b0) begin
      n_err++;
      $display("FAIL %s frozen: cc=%0d done=%b busy=%b crst=%b wr_en=%b",
               nm, cc_s[d], done_s[d], busy_s[d], core_rst_s[d], wr_en_s[d]);
    end
  endtask

  task automatic test_three_word();
    logic [31:0] q[$];
    q = {32'h0022_1820, 32'h0000_0000, 32'h0000_000C};
    load_and_run(0, q, 1'b1, 0, "three_word");
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back(32'h1111_0000 + 32'(i));
    load_and_run(1, q, 1'b0, 0, "backpressure");
  endtask

  task automatic test_timeout();
    logic [31:0] q[$];
    q = {NOP_WORD, NOP_WORD, NOP_WORD};
    load_and_run(0, q, 1'b1, 1, "timeout");
  endtask

  task automatic test_halt_at_budget();
    logic [31:0] q[$];
    for (int i = 0; i < 15; i++) q.push_back(32'h0000_0000);
    q.push_back(32'h0000_000C);
    load_and_run(0, q, 1'b1, 0, "halt_at_budget");
  endtask

  task automatic test_abort();
    @(negedge CLK);
    start_s[0] = 1'b1;
    @(negedge CLK);
    start_s[0]    = 1'b0;
    in_valid_s[0] = 1'b1;
    in_data_s[0]  = 32'hAAAA_0001;
    @(negedge CLK);
    in_data_s[0]  = 32'hAAAA_0002;
    @(negedge CLK);
    in_valid_s[0] = 1'b0;
    n_vec++;
    if (lc_s[0] != 2 || busy_s[0] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre: lc=%0d busy=%b want 2/1", lc_s[0], busy_s[0]);
    end
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if (lc_s[0] != 0 || busy_s[0] !== 1'b0 || core_rst_s[0] !== 1'b1
        || wr_en_s[0] !== 1'b0 || in_ready_s[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: lc=%0d busy=%b crst=%b wr_en=%b rdy=%b",
               lc_s[0], busy_s[0], core_rst_s[0], wr_en_s[0], in_ready_s[0]);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (busy_s[0] !== 1'b0 || in_ready_s[0] !== 1'b0 || lc_s[0] != 0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b rdy=%b lc=%0d want 0/0/0",
               busy_s[0], in_ready_s[0], lc_s[0]);
    end
  endtask

  task automatic test_restart();
    logic [31:0] q[$];
    q = {32'h2001_0005, 32'h0000_000C};
    load_and_run(0, q, 1'b1, 0, "restart_a");
    q = {32'h3C01_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_000C};
    load_and_run(0, q, 1'b1, 2, "restart_b");
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int len;
    bit ml;
    for (int it = 0; it < 16; it++) begin
      int d;
      d = it % 2;
      q.delete();
      len = (d == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) q.push_back(32'h0000_000C);
        else q.push_back($urandom());
      end
      ml = (d == 1 && len >= 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      load_and_run(d, q, ml, 2, (d == 0) ? "random_a" : "random_b");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int d = 0; d < 2; d++) begin
      start_s[d]    = 1'b0;
      in_valid_s[d] = 1'b0;
      in_last_s[d]  = 1'b0;
      in_data_s[d]  = 32'h0;
      mem_clr[d]    = 1'b0;
    end
    test_reset();
    test_three_word();
    test_backpressure();
    test_timeout();
    test_halt_at_budget();
    test_abort();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
